// File: rtl/fifo_psram_wbuf_v1.sv
// Write-side line buffer: packs 16-bit pixel pairs into 32-bit words and hands
// them to the pSRAM write controller in bursts with a one-cycle read latency.
module fifo_psram_wbuf_v1 #(
    parameter int AW    = 7,
    parameter int BURST = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sol,
    input  logic          flush,
    input  logic          din_vld,
    input  logic [15:0]   din,
    output logic          burst_req,
    input  logic          burst_ack,
    output logic [AW:0]   burst_len,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic          rd_vld,
    output logic [AW:0]   level,
    output logic          ovf
);

    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] BURST_W = (AW+1)'(BURST);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t      state, state_nxt;
    logic [31:0] mem [0:(1<<AW)-1];
    logic [AW:0] wptr, rptr, rd_cnt;
    logic        phase, phase_nxt;
    logic        flush_pend;
    logic [15:0] held, held_nxt;
    logic        full;
    logic        wr_req, wr_en, rd_acc;
    logic [31:0] wr_word;
    logic        latch_len, last_rd;
    logic [31:0] rd_data_p1;
    logic        vld_p1;

    // A burst never asks for more than is stored, nor more than one full burst.
    function automatic logic [AW:0] clip_len(input logic [AW:0] lvl);
        return (lvl < BURST_W) ? lvl : BURST_W;
    endfunction

    assign level   = wptr - rptr;
    assign full    = (level == DEPTH);
    assign wr_en   = wr_req && !full;
    assign rd_acc  = (state == XFER) && rd_en && (level != '0);
    assign rd_data = rd_data_p1;
    assign rd_vld  = vld_p1;

    // sol wins over everything; a flush with a lone pixel pads it with zero.
    always_comb begin
        wr_req    = 1'b0;
        wr_word   = {16'h0000, held};
        phase_nxt = phase;
        held_nxt  = held;
        if (sol) begin
            phase_nxt = din_vld;
            if (din_vld)
                held_nxt = din;
        end else if (din_vld && phase) begin
            wr_req    = 1'b1;
            wr_word   = {din, held};
            phase_nxt = 1'b0;
        end else if (din_vld && flush) begin
            wr_req    = 1'b1;
            wr_word   = {16'h0000, din};
            phase_nxt = 1'b0;
        end else if (din_vld) begin
            held_nxt  = din;
            phase_nxt = 1'b1;
        end else if (flush && phase) begin
            wr_req    = 1'b1;
            wr_word   = {16'h0000, held};
            phase_nxt = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        burst_req = 1'b0;
        latch_len = 1'b0;
        last_rd   = rd_acc && ((rd_cnt + 1'b1) == burst_len);
        case (state)
            IDLE: begin
                if (level >= BURST_W || (flush_pend && level != '0)) begin
                    state_nxt = REQ;
                    latch_len = 1'b1;
                end
            end
            REQ: begin
                burst_req = 1'b1;
                if (burst_ack)
                    state_nxt = XFER;
            end
            XFER: begin
                if (last_rd)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: control state, pointers and the registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wptr       <= '0;
            rptr       <= '0;
            rd_cnt     <= '0;
            phase      <= 1'b0;
            flush_pend <= 1'b0;
            ovf        <= 1'b0;
            burst_len  <= '0;
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            state  <= state_nxt;
            phase  <= phase_nxt;
            vld_p1 <= rd_acc;
            if (wr_en)
                wptr <= wptr + 1'b1;
            if (wr_req && full)
                ovf <= 1'b1;
            if (flush)
                flush_pend <= 1'b1;
            else if (state == IDLE && level == '0)
                flush_pend <= 1'b0;
            if (latch_len) begin
                burst_len <= clip_len(level);
                rd_cnt    <= '0;
            end else if (rd_acc) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (rd_acc) begin
                rptr       <= rptr + 1'b1;
                rd_data_p1 <= mem[rptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        held <= held_nxt;
        if (wr_en)
            mem[wptr[AW-1:0]] <= wr_word;
    end

endmodule
